lock_disp_seq: RTL and testbench
================================

// Module: lock_disp_seq
// PURPOSE
//  Display sequencer for the electronic lock. Decides what the 5-digit 7-seg display shows:
//  "CLOSE", the keypad digits being entered, a blinking "-----" error banner, or "OPEn".
//  Drives dig4..dig0 / dispen of the display block; sits between lock core/keypad and display.
//  Digit codes: 0-9 numerals, a='-', b='L', c='C', d='n', e='E', f='P'.
// PARAMETERS
//  TIMEOUT_TICKS  160  hz32 ticks with no accepted digit before ENTRY reverts to CLOSED (5 s)
//  ERR_TICKS      64   hz32 ticks the error banner is held (2 s)
//  BLINK_TICKS    8    hz32 ticks per blink half-period in ERROR (2 Hz blink)
// PORTS
//  ck        in   1  system clock
//  resetn    in   1  asynchronous, active-low reset
//  hz32      in   1  32 Hz enable pulse, exactly one ck wide
//  key_valid in   1  one-ck pulse: key_code is valid
//  key_code  in   4  0-9 digit, 4'ha clear, 4'hb-4'hf ignored
//  lock_open in   1  level from lock core: 1 = lock open
//  err       in   1  one-ck pulse from lock core: wrong code entered
//  dig4..dig0 out 4  digit codes to display (dig4 leftmost); registered
//  dispen    out  5  per-digit enable, bit4 = dig4; registered
// BEHAVIOUR
//  - All outputs registered; an event on cycle N is visible on outputs at N+1.
//  - Reset: state CLOSED, dig4..0 = c,b,0,5,e ("CLOSE"), dispen = 5'b11111, counters 0.
//  - tcnt: counts hz32 pulses; cleared on every state entry and on every accepted digit.
//    "Expiry of N" = hz32 high while tcnt == N-1 (transition takes effect on that edge).
//  - States and outputs:
//    CLOSED: "CLOSE", dispen 11111.
//    ENTRY : digits shown right-justified; dispen has one bit set per entered digit, from bit0.
//    ERROR : dig4..0 = a,a,a,a,a; dispen 11111 (on phase) / 00000 (off phase).
//    OPEN  : dig4..0 = 0,0,f,e,d ("OPEn"); dispen 01111.
//  - Priority each cycle: lock_open > err > key_valid > tick expiry.
//  - Transitions:
//    any state, lock_open=1          -> OPEN (ERROR/ENTRY abandoned, entered digits discarded).
//    OPEN, lock_open falls           -> CLOSED. err/keys ignored while OPEN.
//    CLOSED/ENTRY, err               -> ERROR, blink phase = on, blink counter cleared.
//    CLOSED, digit key k             -> ENTRY, dig0=k, dig4..1=0, dispen 00001.
//    ENTRY, digit key k              -> shift left (dig4<=dig3 ... dig0<=k); dispen <= {dispen[3:0],1};
//                                       6th+ digit drops oldest, dispen stays 11111.
//    ENTRY, key 4'ha                 -> CLOSED. CLOSED, key 4'ha -> no change.
//    keys 4'hb-4'hf                  -> no effect anywhere; do not clear tcnt.
//    ENTRY, expiry of TIMEOUT_TICKS  -> CLOSED.
//    ERROR, keys/err                 -> ignored; err does not restart the hold.
//    ERROR, every BLINK_TICKS ticks  -> toggle blink phase.
//    ERROR, expiry of ERR_TICKS      -> CLOSED.
//  - Reset asserted mid-operation returns to reset values immediately (async), no partial state.
//  - Unused/undecodable state encodings recover to CLOSED on the next ck.
// TESTING
//  1 reset, release -> dig4..0 = c,b,0,5,e, dispen 11111, held indefinitely with no input.
//  2 keys 1,2,3 -> dig2..0 = 1,2,3, dispen 00111; then keys 4,5,6 -> dig4..0 = 2,3,4,5,6, dispen 11111;
//    key 4'ha -> "CLOSE".
//  3 key 7 then 159 hz32 pulses -> still ENTRY; 160th pulse -> "CLOSE" next ck; a key at pulse 100
//    restarts count (needs 160 more).
//  4 err in CLOSED -> "-----" dispen 11111; toggles to 00000 after 8 ticks, back after 16;
//    after 64 ticks -> "CLOSE"; keys during ERROR ignored.
//  5 lock_open=1 during ENTRY -> 0,0,f,e,d dispen 01111; err same cycle -> still OPEN;
//    lock_open=0 -> "CLOSE".
//  6 resetn pulsed low mid-ERROR (off phase) -> "CLOSE", dispen 11111 immediately, no ck needed.

Source files
------------

// File: rtl/lock_disp_seq.sv
// -----------------------------------------------------------------------------
// lock_disp_seq
//   Display sequencer for the electronic lock. Chooses what the 5-digit 7-seg
//   display shows: "CLOSE", the keypad digits being entered, a blinking "-----"
//   error banner, or "OPEn". Sits between the lock core / keypad and the
//   display block.
//
//   Digit codes: 0-9 numerals, a='-', b='L', c='C', d='n', e='E', f='P'.
//
// Ports
//   ck          in   system clock
//   resetn      in   asynchronous active-low reset
//   hz32        in   32 Hz enable pulse, one ck wide
//   key_valid   in   one-ck pulse qualifying key_code
//   key_code    in   [3:0] 0-9 digit, 4'ha clear, 4'hb-4'hf ignored
//   lock_open   in   level from lock core, 1 = lock open
//   err         in   one-ck pulse from lock core: wrong code entered
//   dig4..dig0  out  [3:0] registered digit codes, dig4 leftmost
//   dispen      out  [4:0] registered per-digit enables, bit4 = dig4
// -----------------------------------------------------------------------------
module lock_disp_seq #(
    parameter int unsigned TIMEOUT_TICKS = 160,
    parameter int unsigned ERR_TICKS     = 64,
    parameter int unsigned BLINK_TICKS   = 8
) (
    input  logic       ck,
    input  logic       resetn,
    input  logic       hz32,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       lock_open,
    input  logic       err,
    output logic [3:0] dig4,
    output logic [3:0] dig3,
    output logic [3:0] dig2,
    output logic [3:0] dig1,
    output logic [3:0] dig0,
    output logic [4:0] dispen
);

    localparam int unsigned TMAX = (TIMEOUT_TICKS > ERR_TICKS) ? TIMEOUT_TICKS : ERR_TICKS;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned BW   = $clog2(BLINK_TICKS + 1);

    localparam logic [3:0] C_DASH = 4'ha;
    localparam logic [3:0] C_L    = 4'hb;
    localparam logic [3:0] C_C    = 4'hc;
    localparam logic [3:0] C_N    = 4'hd;
    localparam logic [3:0] C_E    = 4'he;
    localparam logic [3:0] C_P    = 4'hf;

    typedef enum logic [1:0] {
        S_CLOSED,
        S_ENTRY,
        S_ERROR,
        S_OPEN
    } state_t;

    state_t          state;
    logic [TW-1:0]   tcnt;
    logic [BW-1:0]   bcnt;
    logic            phase;

    logic key_digit;
    logic key_clear;
    logic t_expire;
    logic e_expire;
    logic b_expire;

    assign key_digit = key_valid && (key_code <= 4'd9);
    assign key_clear = key_valid && (key_code == 4'ha);
    assign t_expire  = hz32 && (tcnt == TW'(TIMEOUT_TICKS - 1));
    assign e_expire  = hz32 && (tcnt == TW'(ERR_TICKS - 1));
    assign b_expire  = hz32 && (bcnt == BW'(BLINK_TICKS - 1));

    // Outputs are computed alongside the next state so they appear one ck
    // after the event that caused them.
    always_ff @(posedge ck or negedge resetn) begin
        if (!resetn) begin
            state  <= S_CLOSED;
            tcnt   <= '0;
            bcnt   <= '0;
            phase  <= 1'b1;
            dig4   <= C_C;
            dig3   <= C_L;
            dig2   <= 4'd0;
            dig1   <= 4'd5;
            dig0   <= C_E;
            dispen <= '1;
        end else begin
            if (lock_open) begin
                // Open overrides everything; entered digits and error hold are dropped.
                state  <= S_OPEN;
                tcnt   <= '0;
                bcnt   <= '0;
                dig4   <= 4'd0;
                dig3   <= 4'd0;
                dig2   <= C_P;
                dig1   <= C_E;
                dig0   <= C_N;
                dispen <= 5'b01111;
            end else begin
                case (state)
                    S_CLOSED: begin
                        if (err) begin
                            state  <= S_ERROR;
                            tcnt   <= '0;
                            bcnt   <= '0;
                            phase  <= 1'b1;
                            dig4   <= C_DASH;
                            dig3   <= C_DASH;
                            dig2   <= C_DASH;
                            dig1   <= C_DASH;
                            dig0   <= C_DASH;
                            dispen <= '1;
                        end else if (key_digit) begin
                            state  <= S_ENTRY;
                            tcnt   <= '0;
                            dig4   <= 4'd0;
                            dig3   <= 4'd0;
                            dig2   <= 4'd0;
                            dig1   <= 4'd0;
                            dig0   <= key_code;
                            dispen <= 5'b00001;
                        end
                    end

                    S_ENTRY: begin
                        if (err) begin
                            state  <= S_ERROR;
                            tcnt   <= '0;
                            bcnt   <= '0;
                            phase  <= 1'b1;
                            dig4   <= C_DASH;
                            dig3   <= C_DASH;
                            dig2   <= C_DASH;
                            dig1   <= C_DASH;
                            dig0   <= C_DASH;
                            dispen <= '1;
                        end else if (key_digit) begin
                            // Shift register of digits; once full the oldest falls off dig4.
                            tcnt   <= '0;
                            dig4   <= dig3;
                            dig3   <= dig2;
                            dig2   <= dig1;
                            dig1   <= dig0;
                            dig0   <= key_code;
                            dispen <= {dispen[3:0], 1'b1};
                        end else if (key_clear || t_expire) begin
                            state  <= S_CLOSED;
                            tcnt   <= '0;
                            dig4   <= C_C;
                            dig3   <= C_L;
                            dig2   <= 4'd0;
                            dig1   <= 4'd5;
                            dig0   <= C_E;
                            dispen <= '1;
                        end else if (hz32) begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end

                    S_ERROR: begin
                        if (e_expire) begin
                            state  <= S_CLOSED;
                            tcnt   <= '0;
                            bcnt   <= '0;
                            dig4   <= C_C;
                            dig3   <= C_L;
                            dig2   <= 4'd0;
                            dig1   <= 4'd5;
                            dig0   <= C_E;
                            dispen <= '1;
                        end else if (hz32) begin
                            tcnt <= tcnt + TW'(1);
                            if (b_expire) begin
                                bcnt   <= '0;
                                phase  <= ~phase;
                                dispen <= phase ? 5'b00000 : 5'b11111;
                            end else begin
                                bcnt <= bcnt + BW'(1);
                            end
                        end
                    end

                    S_OPEN: begin
                        state  <= S_CLOSED;
                        tcnt   <= '0;
                        dig4   <= C_C;
                        dig3   <= C_L;
                        dig2   <= 4'd0;
                        dig1   <= 4'd5;
                        dig0   <= C_E;
                        dispen <= '1;
                    end

                    default: begin
                        state  <= S_CLOSED;
                        tcnt   <= '0;
                        bcnt   <= '0;
                        phase  <= 1'b1;
                        dig4   <= C_C;
                        dig3   <= C_L;
                        dig2   <= 4'd0;
                        dig1   <= 4'd5;
                        dig0   <= C_E;
                        dispen <= '1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lock_disp_seq.sv
module tb_lock_disp_seq;

    localparam int TOUT  = 160;
    localparam int ETICK = 64;
    localparam int BTICK = 8;

    localparam logic [24:0] O_CLOSE = {20'hcb05e, 5'b11111};
    localparam logic [24:0] O_OPEN  = {20'h00fed, 5'b01111};
    localparam logic [24:0] O_ERRON = {20'haaaaa, 5'b11111};
    localparam logic [24:0] O_ERROF = {20'haaaaa, 5'b00000};

    logic       ck = 1'b0;
    logic       resetn;
    logic       hz32;
    logic       key_valid;
    logic [3:0] key_code;
    logic       lock_open;
    logic       err;
    logic [3:0] dig4, dig3, dig2, dig1, dig0;
    logic [4:0] dispen;

    lock_disp_seq #(
        .TIMEOUT_TICKS(160),
        .ERR_TICKS    (64),
        .BLINK_TICKS  (8)
    ) dut (
        .ck       (ck),
        .resetn   (resetn),
        .hz32     (hz32),
        .key_valid(key_valid),
        .key_code (key_code),
        .lock_open(lock_open),
        .err      (err),
        .dig4     (dig4),
        .dig3     (dig3),
        .dig2     (dig2),
        .dig1     (dig1),
        .dig0     (dig0),
        .dispen   (dispen)
    );

    always #5 ck = ~ck;

    int passed = 0;
    int total  = 0;

    // Behavioural model: a mode, the list of entered digits, and tick counts.
    int mode;      // 0 closed, 1 entry, 2 error, 3 open
    int digs[$];
    int idle;
    int eticks;

    task automatic model_reset();
        mode = 0;
        digs.delete();
        idle = 0;
        eticks = 0;
    endtask

    task automatic model_step(input logic lo, input logic er, input logic kv,
                              input logic [3:0] kc, input logic hz);
        bit is_digit = kv && (kc <= 4'd9);
        if (lo) begin
            mode = 3;
            digs.delete();
        end else begin
            case (mode)
                3: mode = 0;
                0: begin
                    if (er) begin
                        mode = 2; eticks = 0;
                    end else if (is_digit) begin
                        mode = 1; digs.delete(); digs.push_back(int'(kc)); idle = 0;
                    end
                end
                1: begin
                    if (er) begin
                        mode = 2; eticks = 0; digs.delete();
                    end else if (is_digit) begin
                        digs.push_back(int'(kc));
                        if (digs.size() > 5) void'(digs.pop_front());
                        idle = 0;
                    end else if (kv && kc == 4'ha) begin
                        mode = 0; digs.delete();
                    end else if (hz) begin
                        idle++;
                        if (idle >= TOUT) begin mode = 0; digs.delete(); end
                    end
                end
                default: begin
                    if (hz) begin
                        eticks++;
                        if (eticks >= ETICK) mode = 0;
                    end
                end
            endcase
        end
    endtask

    function automatic logic [24:0] model_out();
        logic [19:0] d;
        int n;
        d = '0;
        case (mode)
            0: return O_CLOSE;
            3: return O_OPEN;
            2: return ((eticks / BTICK) % 2 == 0) ? O_ERRON : O_ERROF;
            default: begin
                n = digs.size();
                for (int i = 0; i < n; i++) d[i*4 +: 4] = 4'(digs[n-1-i]);
                return {d, 5'((1 << n) - 1)};
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [24:0] exp);
        logic [24:0] act;
        act = {dig4, dig3, dig2, dig1, dig0, dispen};
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got dig=%h en=%b, expected dig=%h en=%b",
                      name, act[24:5], act[4:0], exp[24:5], exp[4:0]);
    endtask

    task automatic cyc(input logic lo, input logic er, input logic kv,
                       input logic [3:0] kc, input logic hz);
        lock_open = lo; err = er; key_valid = kv; key_code = kc; hz32 = hz;
        model_step(lo, er, kv, kc, hz);
        @(posedge ck);
        #1;
        check("model", model_out());
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic tick();
        cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    endtask

    task automatic key(input logic [3:0] k);
        cyc(1'b0, 1'b0, 1'b1, k, 1'b0);
    endtask

    typedef struct {
        logic        lo;
        logic        er;
        logic        kv;
        logic [3:0]  kc;
        logic        hz;
        logic [24:0] exp;
    } vec_t;

    vec_t tbl[17];

    initial begin
        logic lo_lvl;

        tbl[0]  = '{1'b0, 1'b0, 1'b1, 4'h1, 1'b0, {20'h00001, 5'b00001}};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 4'h2, 1'b0, {20'h00012, 5'b00011}};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 4'h3, 1'b0, {20'h00123, 5'b00111}};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 4'h4, 1'b0, {20'h01234, 5'b01111}};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 4'h5, 1'b0, {20'h12345, 5'b11111}};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 4'h6, 1'b0, {20'h23456, 5'b11111}};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 4'hb, 1'b0, {20'h23456, 5'b11111}};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 4'ha, 1'b0, O_CLOSE};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 4'ha, 1'b0, O_CLOSE};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 4'h9, 1'b0, {20'h00009, 5'b00001}};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, O_OPEN};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 4'h3, 1'b1, O_OPEN};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, O_CLOSE};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, O_ERRON};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 4'h5, 1'b0, O_ERRON};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, O_OPEN};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, O_CLOSE};

        resetn = 1'b0; hz32 = 1'b0; key_valid = 1'b0; key_code = 4'h0;
        lock_open = 1'b0; err = 1'b0;
        model_reset();
        #12;
        check("reset_state", O_CLOSE);
        @(negedge ck);
        resetn = 1'b1;
        for (int i = 0; i < 20; i++) idle_cyc();
        check("close_held", O_CLOSE);

        // Table vectors
        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].lo, tbl[i].er, tbl[i].kv, tbl[i].kc, tbl[i].hz);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Entry timeout boundary
        key(4'h7);
        for (int i = 0; i < TOUT - 1; i++) tick();
        check("timeout_159", {20'h00007, 5'b00001});
        tick();
        check("timeout_160", O_CLOSE);

        // A digit at pulse 100 restarts the timeout
        key(4'h7);
        for (int i = 0; i < 99; i++) tick();
        cyc(1'b0, 1'b0, 1'b1, 4'h8, 1'b1);
        for (int i = 0; i < TOUT - 1; i++) tick();
        check("restart_159", {20'h00078, 5'b00011});
        tick();
        check("restart_160", O_CLOSE);

        // Ignored key on the expiring tick does not save the entry
        key(4'h4);
        for (int i = 0; i < TOUT - 1; i++) tick();
        cyc(1'b0, 1'b0, 1'b1, 4'hc, 1'b1);
        check("badkey_expiry", O_CLOSE);

        // Error banner blink and hold
        cyc(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
        check("err_enter", O_ERRON);
        for (int i = 0; i < BTICK - 1; i++) tick();
        check("blink_7", O_ERRON);
        tick();
        check("blink_8", O_ERROF);
        key(4'h3);
        cyc(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
        check("err_keys_ignored", O_ERROF);
        for (int i = 0; i < BTICK; i++) tick();
        check("blink_16", O_ERRON);
        for (int i = 16; i < ETICK - 1; i++) tick();
        check("hold_63", O_ERROF);
        tick();
        check("hold_64", O_CLOSE);

        // Asynchronous reset during the off phase of the banner
        cyc(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < BTICK; i++) tick();
        check("pre_reset_off", O_ERROF);
        hz32 = 1'b0; err = 1'b0; key_valid = 1'b0; lock_open = 1'b0;
        resetn = 1'b0;
        #2;
        check("async_reset", O_CLOSE);
        model_reset();
        @(negedge ck);
        resetn = 1'b1;
        idle_cyc();

        // Randomized traffic against the model
        lo_lvl = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 199) == 0) lo_lvl = ~lo_lvl;
            cyc(lo_lvl,
                ($urandom_range(0, 149) == 0),
                ($urandom_range(0, 14) == 0),
                4'($urandom_range(0, 15)),
                ($urandom_range(0, 1) == 1));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
